// File: rtl/act_pwq_pipe.sv
// Three-stage piecewise-quadratic activation (sigmoid/tanh/ReLU/identity) with
// valid/ready flow control, a sideband tag and a saturation flag per sample.
module act_pwq_pipe #(
  parameter int WIDTH = 32,
  parameter int FL    = 24,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic [1:0]              in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_sat
);

  typedef logic signed [WIDTH-1:0]   word_t;
  typedef logic signed [WIDTH+1:0]   wide_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;

  localparam logic [1:0] M_SIG  = 2'd0;
  localparam logic [1:0] M_TANH = 2'd1;
  localparam logic [1:0] M_RELU = 2'd2;

  function automatic word_t quant(input real v);
    real sc;
    sc = v * (2.0 ** FL);
    sc = (sc < 0.0) ? sc - 0.5 : sc + 0.5;
    return word_t'($rtoi(sc));
  endfunction

  function automatic word_t fx_mul(input word_t a, input word_t b);
    prod_t p;
    p = prod_t'(a) * prod_t'(b);
    return p[FL+WIDTH-1:FL];
  endfunction

  localparam word_t ONE    = word_t'(1) << FL;
  localparam word_t MAXV   = word_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam word_t MINV   = word_t'({1'b1, {(WIDTH-1){1'b0}}});
  localparam word_t TH_HI  = word_t'(6) << FL;
  localparam word_t TH_MID = word_t'(7) << (FL - 1);
  localparam word_t TH_LO  = word_t'(3) << (FL - 1);
  localparam wide_t ONE_W  = wide_t'(ONE);

  localparam word_t C2_P1 = quant(-0.0046090);
  localparam word_t C2_P2 = quant(0.053606);
  localparam word_t C2_P3 = quant(0.840844);
  localparam word_t C1_P1 = quant(-0.029988);
  localparam word_t C1_P2 = quant(0.223978);
  localparam word_t C1_P3 = quant(0.551643);
  localparam word_t C0_P1 = quant(-0.036623);
  localparam word_t C0_P2 = quant(0.269097);
  localparam word_t C0_P3 = quant(0.497822);

  // |most-negative| has no positive twin, so it pins to the largest code
  function automatic word_t abs_sat(input word_t a);
    if (a == MINV) return MAXV;
    if (a < 0)     return -a;
    return a;
  endfunction

  function automatic word_t dbl_sat(input word_t v);
    if (v[WIDTH-2]) return MAXV;
    return v <<< 1;
  endfunction

  function automatic word_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
    wide_t r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return word_t'(r);
  endfunction

  logic adv;
  assign adv      = en & (~out_valid | out_ready);
  assign in_ready = adv;

  // ---- stage 0 -> 1: magnitude, segment select, square
  logic  sign_p0, sat_p0;
  word_t mag_p0, x_p0, x2_p0, p1_p0, p2_p0, p3_p0;

  always_comb begin
    sign_p0 = in_data[WIDTH-1];
    mag_p0  = abs_sat(in_data);
    x_p0    = (in_mode == M_TANH) ? dbl_sat(mag_p0) : mag_p0;
    x2_p0   = fx_mul(x_p0, x_p0);
    sat_p0  = 1'b0;
    p1_p0   = C0_P1;
    p2_p0   = C0_P2;
    p3_p0   = C0_P3;
    if (x_p0 >= TH_HI) begin
      p1_p0  = '0;
      p2_p0  = '0;
      p3_p0  = ONE;
      sat_p0 = 1'b1;
    end else if (x_p0 >= TH_MID) begin
      p1_p0 = C2_P1;
      p2_p0 = C2_P2;
      p3_p0 = C2_P3;
    end else if (x_p0 >= TH_LO) begin
      p1_p0 = C1_P1;
      p2_p0 = C1_P2;
      p3_p0 = C1_P3;
    end
  end

  logic              vld_p1, sign_p1, sat_p1;
  logic [1:0]        mode_p1;
  logic [TAG_W-1:0]  tag_p1;
  word_t             a_p1, x_p1, x2_p1, p1_p1, p2_p1, p3_p1;

  // ---- stage 1 -> 2: polynomial evaluation
  logic              vld_p2, sign_p2, sat_p2;
  logic [1:0]        mode_p2;
  logic [TAG_W-1:0]  tag_p2;
  word_t             a_p2, f_p2, f_p1n;

  assign f_p1n = fx_mul(p1_p1, x2_p1) + fx_mul(p2_p1, x_p1) + p3_p1;

  // ---- stage 2 -> out: symmetry fold, tanh mapping, clamp
  wide_t fw_p2, v_p2;
  word_t y_p2n;
  logic  sat_p2n;

  assign fw_p2 = wide_t'(f_p2);

  always_comb begin
    v_p2    = '0;
    y_p2n   = a_p2;
    sat_p2n = 1'b0;
    case (mode_p2)
      M_SIG: begin
        v_p2    = sign_p2 ? ONE_W - fw_p2 : fw_p2;
        y_p2n   = clamp(v_p2, '0, ONE_W);
        sat_p2n = sat_p2;
      end
      M_TANH: begin
        v_p2    = (fw_p2 <<< 1) - ONE_W;
        if (sign_p2) v_p2 = -v_p2;
        y_p2n   = clamp(v_p2, -ONE_W, ONE_W);
        sat_p2n = sat_p2;
      end
      M_RELU:  y_p2n = sign_p2 ? '0 : a_p2;
      default: y_p2n = a_p2;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      out_data  <= y_p2n;
      out_tag   <= tag_p2;
      out_sat   <= sat_p2n;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_p1    <= in_data;
      x_p1    <= x_p0;
      x2_p1   <= x2_p0;
      p1_p1   <= p1_p0;
      p2_p1   <= p2_p0;
      p3_p1   <= p3_p0;
      sign_p1 <= sign_p0;
      sat_p1  <= sat_p0;
      mode_p1 <= in_mode;
      tag_p1  <= in_tag;

      a_p2    <= a_p1;
      f_p2    <= f_p1n;
      sign_p2 <= sign_p1;
      sat_p2  <= sat_p1;
      mode_p2 <= mode_p1;
      tag_p2  <= tag_p1;
    end
  end

endmodule

// File: tb/tb_act_pwq_pipe.sv
// Directed and randomised bench for act_pwq_pipe with a queue-based scoreboard
// fed by an independent 64-bit reference model of the activation.
module tb_act_pwq_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_data = '0;
  logic [1:0]         in_mode = '0;
  logic [7:0]         in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] out_data;
  logic [7:0]         out_tag;
  logic               out_sat;

  act_pwq_pipe #(.WIDTH(32), .FL(24), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic [7:0]  tag;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  bit   last_acc = 0;
  bit   rand_ctl = 0;

  localparam longint ONE  = 64'sd16777216;
  localparam longint MAXV = 64'sd2147483647;

  function automatic longint qr(input real v);
    return longint'($rtoi($floor(v * 16777216.0 + 0.5)));
  endfunction

  function automatic void ref_model(input logic [31:0] a, input logic [1:0] m,
                                    output logic [31:0] y, output logic sat);
    longint av, x, x2, p1, p2, p3, t1, t2, f, r;
    bit s;
    av = longint'(signed'(a));
    s  = (av < 0);
    x  = s ? -av : av;
    if (x > MAXV) x = MAXV;
    if (m == 2'd1) begin
      x = 2 * x;
      if (x > MAXV) x = MAXV;
    end
    sat = 1'b0;
    if (x >= 6 * ONE) begin
      p1 = 0; p2 = 0; p3 = ONE; sat = 1'b1;
    end else if (2 * x >= 7 * ONE) begin
      p1 = qr(-0.0046090); p2 = qr(0.053606); p3 = qr(0.840844);
    end else if (2 * x >= 3 * ONE) begin
      p1 = qr(-0.029988); p2 = qr(0.223978); p3 = qr(0.551643);
    end else begin
      p1 = qr(-0.036623); p2 = qr(0.269097); p3 = qr(0.497822);
    end
    x2 = longint'(int'((x * x) >>> 24));
    t1 = longint'(int'((p1 * x2) >>> 24));
    t2 = longint'(int'((p2 * x) >>> 24));
    f  = longint'(int'(t1 + t2 + p3));
    case (m)
      2'd0: begin
        r = s ? ONE - f : f;
        if (r < 0) r = 0;
        if (r > ONE) r = ONE;
      end
      2'd1: begin
        r = 2 * f - ONE;
        if (s) r = -r;
        if (r < -ONE) r = -ONE;
        if (r > ONE) r = ONE;
      end
      2'd2:    r = s ? 0 : av;
      default: r = av;
    endcase
    y = r[31:0];
    if (m >= 2'd2) sat = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: sample around the negedge, score any output transfer, step to next negedge.
  task automatic tick();
    exp_t e;
    if (rand_ctl) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready && en) begin
      n_cmp++;
      assert (sb.size() != 0)
      else begin
        n_bad++;
        $error("FAIL unexpected_output: observed tag=%h data=%h, expected no output", out_tag, out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        chk("out_data", out_data, e.y);
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] m, input logic [7:0] t);
    exp_t e;
    logic [31:0] y;
    logic s;
    bit done;
    ref_model(a, m, y, s);
    e = '{y: y, tag: t, sat: s};
    in_data  = a;
    in_mode  = m;
    in_tag   = t;
    in_valid = 1'b1;
    done     = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (last_acc) begin
        sb.push_back(e);
        done = 1;
      end
    end
    in_valid = 1'b0;
    chk("accept_in_time", 32'(done), 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready_en1", 32'(in_ready), 32'd1);
    en = 1'b0;
    #1 chk("in_ready_en0", 32'(in_ready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Latency: out_valid rises on the third edge counting the acceptance edge
    drive(32'h0000_0000, 2'd0, 8'h5A);
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_edge2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_edge3_valid", 32'(out_valid), 32'd1);
    chk("lat_edge3_tag", 32'(out_tag), 32'h5A);
    drain(10);

    // Directed points with hand-known results, back to back
    sb.delete();
    drive(32'h8000_0000, 2'd0, 8'h01);
    sb[0] = '{y: 32'h0000_0000, tag: 8'h01, sat: 1'b1};
    drive(32'h0800_0000, 2'd0, 8'h02);
    sb[sb.size()-1] = '{y: 32'h0100_0000, tag: 8'h02, sat: 1'b1};
    drive(32'hF800_0000, 2'd0, 8'h03);
    sb[sb.size()-1] = '{y: 32'h0000_0000, tag: 8'h03, sat: 1'b1};
    drive(32'h0000_0000, 2'd1, 8'h04);
    drive(32'hFD00_0000, 2'd2, 8'h05);
    sb[sb.size()-1] = '{y: 32'h0000_0000, tag: 8'h05, sat: 1'b0};
    drive(32'h0300_0000, 2'd2, 8'h06);
    sb[sb.size()-1] = '{y: 32'h0300_0000, tag: 8'h06, sat: 1'b0};
    drive(32'h1234_5678, 2'd3, 8'h07);
    sb[sb.size()-1] = '{y: 32'h1234_5678, tag: 8'h07, sat: 1'b0};
    drive(32'hFF80_0000, 2'd1, 8'h08);
    drive(32'h0500_0000, 2'd0, 8'h09);
    drive(32'hFE80_0000, 2'd0, 8'h0A);
    drain(20);

    // Backpressure: three fill the pipe, then in_ready drops
    out_ready = 1'b0;
    drive(32'h0100_0000, 2'd0, 8'h01);
    drive(32'hFF00_0000, 2'd1, 8'h02);
    drive(32'hFE00_0000, 2'd2, 8'h03);
    #1 chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_data = 32'h0200_0000; in_mode = 2'd3; in_tag = 8'h04; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_accept", 32'(last_acc), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", out_data, sb[0].y);
      chk("bp_hold_tag", 32'(out_tag), 32'(sb[0].tag));
    end
    out_ready = 1'b1;
    pop0 = n_pop;
    drive(32'h0200_0000, 2'd3, 8'h04);
    drive(32'h0480_0000, 2'd0, 8'h05);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_one_per_cycle", 32'(n_pop - pop0), 32'd5);
    drain(10);

    // Random en / out_ready over a long mixed stream
    rand_ctl = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [1:0]  m;
      m = 2'($urandom_range(0, 3));
      if (i % 3 == 0) a = $urandom;
      else            a = ($urandom & 32'h0FFF_FFFF) - 32'h0800_0000;
      drive(a, m, 8'(i));
      if ($urandom_range(0, 7) == 0) tick();
    end
    drain(400);
    rand_ctl  = 0;
    en        = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset with three samples in flight drops them all
    out_ready = 1'b0;
    drive(32'h0100_0000, 2'd0, 8'hA1);
    drive(32'h0200_0000, 2'd1, 8'hA2);
    drive(32'h0300_0000, 2'd3, 8'hA3);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_sat", 32'(out_sat), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive(32'hFF40_0000, 2'd0, 8'hB1);
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_lat2", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_lat3", 32'(out_valid), 32'd1);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
